// File: rtl/keypad_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_digit_entry
//  Purpose  : 4x4 keypad to BCD entry buffer. Synchronises and debounces the
//             raw key interrupt, decodes the row/col code and maintains a
//             DIGITS-deep BCD shift buffer with clear, backspace and enter.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_digit_entry #(
   parameter  int DIGITS    = 4,
   parameter  int DEBOUNCE  = 4,
   parameter  int FULL_MODE = 0,
   localparam int CW        = $clog2(DIGITS + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          key_row,
   input  logic [1:0]          key_col,
   input  logic                key_int,
   output logic [4*DIGITS-1:0] digits,
   output logic [CW-1:0]       digit_count,
   output logic                full,
   output logic                entry_valid,
   output logic                key_error
);

   localparam int c_cnt_w = $clog2(DEBOUNCE + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEB  = 2'd1,
      ST_HELD = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      K_DIGIT = 3'd0,
      K_CLEAR = 3'd1,
      K_ENTER = 3'd2,
      K_BACK  = 3'd3,
      K_BAD   = 3'd4
   } key_kind_t;

   state_t               state_q, state_d;
   logic                 ki_meta_q, ki_meta_d;
   logic                 ki_s_q, ki_s_d;
   logic [c_cnt_w-1:0]   deb_cnt_q, deb_cnt_d;
   logic [4*DIGITS-1:0]  digits_q, digits_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 entry_valid_q, entry_valid_d;
   logic                 key_error_q, key_error_d;

   key_kind_t            key_kind;
   logic [3:0]           key_digit;
   logic [4*DIGITS-1:0]  shifted;
   logic                 full_w;
   logic                 accept;

   assign full_w = (count_q == CW'(DIGITS));

   // New digit enters at the bottom; a single-digit buffer just takes it.
   generate
      if (DIGITS == 1) begin : g_shift_single
         assign shifted = key_digit;
      end else begin : g_shift_multi
         assign shifted = {digits_q[4*DIGITS-5:0], key_digit};
      end
   endgenerate

   // Decode the keypad row/col code into a key class and digit value.
   always_comb begin
      key_kind  = K_BAD;
      key_digit = 4'd0;
      if (key_row != 2'd3 && key_col != 2'd3) begin
         key_kind  = K_DIGIT;
         key_digit = 4'(key_row) * 4'd3 + 4'(key_col) + 4'd1;
      end else if (key_row == 2'd3 && key_col == 2'd1) begin
         key_kind  = K_DIGIT;
      end else if (key_row == 2'd3 && key_col == 2'd0) begin
         key_kind  = K_CLEAR;
      end else if (key_row == 2'd3 && key_col == 2'd2) begin
         key_kind  = K_ENTER;
      end else if (key_row == 2'd0 && key_col == 2'd3) begin
         key_kind  = K_BACK;
      end
   end

   // Next-state logic: sync chain, debounce FSM and buffer update on accept.
   always_comb begin
      ki_meta_d     = key_int;
      ki_s_d        = ki_meta_q;
      state_d       = state_q;
      deb_cnt_d     = deb_cnt_q;
      digits_d      = digits_q;
      count_d       = count_q;
      entry_valid_d = 1'b0;
      key_error_d   = 1'b0;
      accept        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ki_s_q) begin
               state_d   = ST_DEB;
               deb_cnt_d = c_cnt_w'(1);
            end
         end
         ST_DEB: begin
            if (!ki_s_q) begin
               state_d = ST_IDLE;
            end else if (deb_cnt_q == c_cnt_w'(DEBOUNCE)) begin
               accept  = 1'b1;
               state_d = ST_HELD;
            end else begin
               deb_cnt_d = deb_cnt_q + c_cnt_w'(1);
            end
         end
         ST_HELD: begin
            if (!ki_s_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         case (key_kind)
            K_DIGIT: begin
               if (!full_w) begin
                  digits_d = shifted;
                  count_d  = count_q + CW'(1);
               end else if (FULL_MODE == 0) begin
                  digits_d = shifted;
               end else begin
                  key_error_d = 1'b1;
               end
            end
            K_CLEAR: begin
               digits_d = '0;
               count_d  = '0;
            end
            K_BACK: begin
               if (count_q != '0) begin
                  digits_d = digits_q >> 4;
                  count_d  = count_q - CW'(1);
               end else begin
                  key_error_d = 1'b1;
               end
            end
            K_ENTER: begin
               if (count_q != '0) entry_valid_d = 1'b1;
               else               key_error_d   = 1'b1;
            end
            default: key_error_d = 1'b1;
         endcase
      end
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ki_meta_q     <= 1'b0;
         ki_s_q        <= 1'b0;
         deb_cnt_q     <= '0;
         digits_q      <= '0;
         count_q       <= '0;
         entry_valid_q <= 1'b0;
         key_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         ki_meta_q     <= ki_meta_d;
         ki_s_q        <= ki_s_d;
         deb_cnt_q     <= deb_cnt_d;
         digits_q      <= digits_d;
         count_q       <= count_d;
         entry_valid_q <= entry_valid_d;
         key_error_q   <= key_error_d;
      end
   end

   assign digits      = digits_q;
   assign digit_count = count_q;
   assign full        = full_w;
   assign entry_valid = entry_valid_q;
   assign key_error   = key_error_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_digit_entry
//  Purpose  : Directed self-checking bench for keypad_digit_entry. Drives one
//             key stream into a shifting (FULL_MODE=0), a rejecting
//             (FULL_MODE=1) and a single-digit instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_digit_entry;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] key_row;
   logic [1:0] key_col;
   logic       key_int;

   logic [15:0] a_digits;  logic [2:0] a_count; logic a_full, a_ev, a_ke;
   logic [15:0] b_digits;  logic [2:0] b_count; logic b_full, b_ev, b_ke;
   logic [3:0]  s_digits;  logic       s_count; logic s_full, s_ev, s_ke;

   int tests_run    = 0;
   int tests_failed = 0;

   int a_ev_n = 0, a_ke_n = 0, b_ke_n = 0, s_ev_n = 0, both_n = 0;
   logic [15:0] a_ev_digits = '0;
   logic [2:0]  a_ev_count  = '0;
   int a_ev0, a_ke0, b_ke0, s_ev0;

   always #5 clk = ~clk;

   keypad_digit_entry #(.DIGITS(4), .DEBOUNCE(4), .FULL_MODE(0)) u_fm0 (
      .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
      .key_int(key_int), .digits(a_digits), .digit_count(a_count),
      .full(a_full), .entry_valid(a_ev), .key_error(a_ke));

   keypad_digit_entry #(.DIGITS(4), .DEBOUNCE(4), .FULL_MODE(1)) u_fm1 (
      .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
      .key_int(key_int), .digits(b_digits), .digit_count(b_count),
      .full(b_full), .entry_valid(b_ev), .key_error(b_ke));

   keypad_digit_entry #(.DIGITS(1), .DEBOUNCE(4), .FULL_MODE(0)) u_d1 (
      .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
      .key_int(key_int), .digits(s_digits), .digit_count(s_count),
      .full(s_full), .entry_valid(s_ev), .key_error(s_ke));

   // Pulse counters, sampled away from the active edge.
   always @(negedge clk) begin
      if (a_ev) begin
         a_ev_n      <= a_ev_n + 1;
         a_ev_digits <= a_digits;
         a_ev_count  <= a_count;
      end
      if (a_ke) a_ke_n <= a_ke_n + 1;
      if (b_ke) b_ke_n <= b_ke_n + 1;
      if (s_ev) s_ev_n <= s_ev_n + 1;
      if ((a_ev && a_ke) || (b_ev && b_ke) || (s_ev && s_ke)) both_n <= both_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      @(negedge clk);
      a_ev0 = a_ev_n; a_ke0 = a_ke_n; b_ke0 = b_ke_n; s_ev0 = s_ev_n;
   endtask

   // Hold a key for the given number of cycles, then release and let it settle.
   task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold);
      @(posedge clk); #1;
      key_row = r; key_col = c; key_int = 1'b1;
      repeat (hold) @(posedge clk);
      #1 key_int = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; key_row = '0; key_col = '0; key_int = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digits", a_digits, 0);
      chk("rst_count",  a_count,  0);
      chk("rst_full",   a_full,   0);
      chk("rst_ev",     a_ev,     0);
      chk("rst_ke",     a_ke,     0);
      reset = 1'b0;
      repeat (2) @(posedge clk);

      // Fill the buffer with 4,3,8,0
      snap();
      press(2'd1, 2'd0, 10);
      press(2'd0, 2'd2, 10);
      press(2'd2, 2'd1, 10);
      press(2'd3, 2'd1, 10);
      chk("fill_digits",  a_digits, 16'h4380);
      chk("fill_count",   a_count,  4);
      chk("fill_full",    a_full,   1);
      chk("fill_no_err",  a_ke_n - a_ke0, 0);
      chk("fill1_digits", b_digits, 16'h4380);
      chk("d1_digit",     s_digits, 4'h0);
      chk("d1_full",      s_full,   1);

      // Digit 7 while full
      snap();
      press(2'd2, 2'd0, 10);
      chk("full0_digits", a_digits, 16'h3807);
      chk("full0_count",  a_count,  4);
      chk("full0_no_err", a_ke_n - a_ke0, 0);
      chk("full1_digits", b_digits, 16'h4380);
      chk("full1_err",    b_ke_n - b_ke0, 1);
      chk("d1_shift",     s_digits, 4'h7);
      chk("d1_count",     s_count,  1);

      // Backspace, clear, backspace on empty
      press(2'd0, 2'd3, 10);
      chk("bs1_digits", b_digits, 16'h0438);
      chk("bs1_count",  b_count,  3);
      chk("bs0_digits", a_digits, 16'h0380);
      press(2'd3, 2'd0, 10);
      chk("clr_digits", b_digits, 0);
      chk("clr_count",  b_count,  0);
      snap();
      press(2'd3, 2'd0, 10);
      press(2'd0, 2'd3, 10);
      chk("bs_empty_err",    b_ke_n - b_ke0, 1);
      chk("bs_empty_digits", b_digits, 0);

      // Enter 1,2 then '#'
      snap();
      press(2'd0, 2'd0, 10);
      press(2'd0, 2'd1, 10);
      press(2'd3, 2'd2, 10);
      chk("ent_pulses", a_ev_n - a_ev0, 1);
      chk("ent_digits", a_ev_digits, 16'h0012);
      chk("ent_count",  a_ev_count,  2);
      chk("ent_kept",   a_digits,    16'h0012);
      chk("ent_no_err", a_ke_n - a_ke0, 0);
      chk("d1_ent",     s_ev_n - s_ev0, 1);
      press(2'd3, 2'd0, 10);
      snap();
      press(2'd3, 2'd2, 10);
      chk("ent_empty_err", a_ke_n - a_ke0, 1);
      chk("ent_empty_ev",  a_ev_n - a_ev0, 0);

      // Glitch, then a long hold
      snap();
      press(2'd1, 2'd1, 3);
      chk("glitch_count", a_count, 0);
      press(2'd1, 2'd1, 50);
      chk("long_digits", a_digits, 16'h0005);
      chk("long_count",  a_count,  1);
      chk("long_no_err", a_ke_n - a_ke0, 0);

      // Invalid key (2,3)
      snap();
      press(2'd2, 2'd3, 10);
      chk("inv_err",    a_ke_n - a_ke0, 1);
      chk("inv_digits", a_digits, 16'h0005);
      chk("inv_count",  a_count,  1);

      // Reset mid-debounce
      @(posedge clk); #1;
      key_row = 2'd2; key_col = 2'd2; key_int = 1'b1;
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rdeb_digits", a_digits, 0);
      chk("rdeb_count",  a_count,  0);
      key_int = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rdeb_stays", a_count, 0);

      // Reset while a key is held past acceptance
      press(2'd2, 2'd2, 10);
      @(posedge clk); #1;
      key_row = 2'd0; key_col = 2'd1; key_int = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("held_digits", a_digits, 16'h0092);
      #2 reset = 1'b1;
      #1;
      chk("rheld_digits", a_digits, 0);
      chk("rheld_count",  a_count,  0);
      chk("rheld_full",   b_full,   0);
      chk("rheld_ev_ke",  {a_ev, a_ke}, 0);
      key_int = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      chk("never_both", both_n, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
